// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_pkg : shared AHB-lite encodings and the default-slave state type
// Revision: 1.0
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_decoder_mux_if.sv
`default_nettype none
// ============================================================================
// ahb_decoder_mux_if : master-side bus plus per-slave select/response lanes
// Revision: 1.0
// ============================================================================
interface ahb_decoder_mux_if #(
  parameter int NUM_SLAVES = 4
) ();

  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic                     HWRITE;
  logic                     HREADY;
  logic                     HRESP;
  logic [31:0]              HRDATA;
  logic [NUM_SLAVES-1:0]    HSEL_S;
  logic [NUM_SLAVES-1:0]    HREADYOUT_S;
  logic [NUM_SLAVES-1:0]    HRESP_S;
  logic [NUM_SLAVES*32-1:0] HRDATA_S;

  // master: the bus environment (master plus slaves) facing the decoder
  modport master (
    output HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HREADY, HRESP, HRDATA, HSEL_S
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HREADY, HRESP, HRDATA, HSEL_S
  );

endinterface
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// ahb_default_slave : two-cycle ERROR responder for unmapped accesses, with log
// Revision: 1.0
// ============================================================================
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start,
  input  wire logic                hwrite,
  input  wire logic [31:0]         haddr,
  output logic                     ready,
  output logic                     resp,
  output logic [ERRCNT_W-1:0]      err_cnt,
  output logic [32:0]              err_addr
);

  ds_state_t           r_state;
  logic                r_ready;
  logic                r_resp;
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic [32:0]         r_err_addr;
  logic                w_enter_err1;

  assign w_enter_err1 = start && ((r_state == DS_IDLE) || (r_state == DS_ERR2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DS_IDLE;
      r_ready    <= 1'b1;
      r_resp     <= HRESP_OKAY;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if (w_enter_err1) begin
            r_state <= DS_ERR1;
            r_ready <= 1'b0;
            r_resp  <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          r_state <= DS_ERR2;
          r_ready <= 1'b1;
          r_resp  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (w_enter_err1) begin
            r_state <= DS_ERR1;
            r_ready <= 1'b0;
            r_resp  <= HRESP_ERROR;
          end else begin
            r_state <= DS_IDLE;
            r_ready <= 1'b1;
            r_resp  <= HRESP_OKAY;
          end
        end
        default: begin
          r_state <= DS_IDLE;
          r_ready <= 1'b1;
          r_resp  <= HRESP_OKAY;
        end
      endcase
      if (w_enter_err1) begin
        r_err_addr <= {hwrite, haddr};
        if (r_err_cnt != {ERRCNT_W{1'b1}}) begin
          r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
      end
    end
  end

  assign ready    = r_ready;
  assign resp     = r_resp;
  assign err_cnt  = r_err_cnt;
  assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: rtl/ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
// ahb_decoder_mux : AHB-lite address decoder and slave-response multiplexer
// Revision: 1.0
// ============================================================================
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {NUM_SLAVES{32'hF000_0000}},
  parameter int                       ERRCNT_W   = 16
) (
  input  wire logic           HCLK,
  input  wire logic           HRESET,
  ahb_decoder_mux_if.slave    bus,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [32:0]         err_addr
);

  localparam int SEL_W = NUM_SLAVES + 2;
  localparam int DFLT  = NUM_SLAVES;
  localparam logic [SEL_W-1:0] SEL_NONE = {1'b1, {(SEL_W-1){1'b0}}};

  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
      $error("ahb_decoder_mux: NUM_SLAVES must be in 1..8");
    end
  endgenerate

  logic [SEL_W-1:0] w_dec_sel;
  logic [SEL_W-1:0] r_dp_sel;
  logic             w_found;
  logic             w_dflt_start;
  logic             w_ds_ready;
  logic             w_ds_resp;

  // Lowest index wins on overlapping windows; no hit selects the default slave.
  always_comb begin
    w_dec_sel = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!w_found &&
          ((bus.HADDR & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32]))) begin
        w_dec_sel[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
    if (!w_found) begin
      w_dec_sel[DFLT] = 1'b1;
    end
  end

  assign bus.HSEL_S   = w_dec_sel[NUM_SLAVES-1:0];
  assign w_dflt_start = w_dec_sel[DFLT] & bus.HTRANS[1] & bus.HREADY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_sel <= SEL_NONE;
    end else if (bus.HREADY) begin
      r_dp_sel <= w_dec_sel;
    end
  end

  // "none" falls through to the defaults: ready, OKAY, zero data.
  always_comb begin
    bus.HREADY = 1'b1;
    bus.HRESP  = HRESP_OKAY;
    bus.HRDATA = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dp_sel[i]) begin
        bus.HREADY = bus.HREADYOUT_S[i];
        bus.HRESP  = bus.HRESP_S[i];
        bus.HRDATA = bus.HRDATA_S[i*32 +: 32];
      end
    end
    if (r_dp_sel[DFLT]) begin
      bus.HREADY = w_ds_ready;
      bus.HRESP  = w_ds_resp;
    end
  end

  ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_dflt (
    .clk      (HCLK),
    .rst      (HRESET),
    .start    (w_dflt_start),
    .hwrite   (bus.HWRITE),
    .haddr    (bus.HADDR),
    .ready    (w_ds_ready),
    .resp     (w_ds_resp),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
// tb_ahb_decoder_mux : directed transfers with a queue-based data-phase scoreboard
// Revision: 1.0
// ============================================================================
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] err_cnt;
  logic [32:0] err_addr;
  logic        track;
  logic [1:0]  s1_wait;

  int tests = 0;
  int fails = 0;
  int xfer_id = 0;

  typedef struct {
    int          id;
    int          waits;
    logic        wait_resp;
    logic        resp;
    logic [31:0] rdata;
    bit          chk_data;
  } exp_t;
  exp_t sb_q[$];

  ahb_decoder_mux_if #(.NUM_SLAVES(4)) bus ();

  ahb_decoder_mux #(.NUM_SLAVES(4)) dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .bus      (bus),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: fixed read data per slave; slave 1 inserts two wait states.
  assign bus.HRDATA_S    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
  assign bus.HRESP_S     = '0;
  assign bus.HREADYOUT_S = {2'b11, (s1_wait == 2'd0), 1'b1};

  always @(posedge clk or posedge rst) begin
    if (rst) s1_wait <= 2'd0;
    else if (s1_wait != 2'd0) s1_wait <= s1_wait - 2'd1;
    else if (bus.HREADY && bus.HSEL_S[1] && bus.HTRANS[1]) s1_wait <= 2'd2;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [3:0] exp_sel, input int e_waits, input logic e_wresp,
                         input logic e_resp, input logic [31:0] e_rdata, input bit chk);
    exp_t e;
    bit   accepted;
    bus.HADDR  = a;
    bus.HTRANS = t;
    bus.HWRITE = w;
    track      = 1'b1;
    xfer_id++;
    e.id = xfer_id; e.waits = e_waits; e.wait_resp = e_wresp;
    e.resp = e_resp; e.rdata = e_rdata; e.chk_data = chk;
    sb_q.push_back(e);
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      check($sformatf("hsel_x%0d", xfer_id), 64'(bus.HSEL_S), 64'(exp_sel));
      if (bus.HREADY) accepted = 1'b1;
    end
    if (!accepted) check($sformatf("accept_timeout_x%0d", xfer_id), 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.HTRANS = HTRANS_IDLE;
    track      = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: follows data phases and pops the scoreboard on completion.
  bit   pending = 1'b0;
  int   mon_waits = 0;
  logic first_wresp = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (!bus.HREADY) begin
            if (mon_waits == 0) first_wresp = bus.HRESP;
            mon_waits++;
          end else if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            pending = 1'b0;
          end else begin
            e = sb_q.pop_front();
            check($sformatf("waits_x%0d", e.id), 64'(mon_waits), 64'(e.waits));
            if (e.waits > 0)
              check($sformatf("wait_resp_x%0d", e.id), 64'(first_wresp), 64'(e.wait_resp));
            check($sformatf("hresp_x%0d", e.id), 64'(bus.HRESP), 64'(e.resp));
            if (e.chk_data)
              check($sformatf("hrdata_x%0d", e.id), 64'(bus.HRDATA), 64'(e.rdata));
            pending = 1'b0;
          end
        end
        if (bus.HREADY) begin
          pending   = track;
          mon_waits = 0;
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    track      = 1'b0;
    bus.HADDR  = 32'h1000_0000;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;

    // Reset state, decode live during reset
    repeat (2) @(negedge clk);
    check("rst_hready", 64'(bus.HREADY), 64'd1);
    check("rst_hresp",  64'(bus.HRESP),  64'd0);
    check("rst_hrdata", 64'(bus.HRDATA), 64'd0);
    check("rst_errcnt", 64'(err_cnt),    64'd0);
    check("rst_erraddr",64'(err_addr),   64'd0);
    check("rst_hsel",   64'(bus.HSEL_S), 64'h2);
    rst = 1'b0;
    idle(2);

    // Zero-wait reads, pipelined across three slaves
    do_xfer(32'h0000_0010, HTRANS_NONSEQ, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    do_xfer(32'h3000_0008, HTRANS_NONSEQ, 1'b0, 4'b1000, 0, 1'b0, 1'b0, 32'h3333_3333, 1'b1);
    do_xfer(32'h2FFF_FFFC, HTRANS_NONSEQ, 1'b0, 4'b0100, 0, 1'b0, 1'b0, 32'h2222_2222, 1'b1);
    idle(2);

    // Slave 1 stalls the write; the following read's select is held meanwhile
    do_xfer(32'h1000_0000, HTRANS_NONSEQ, 1'b1, 4'b0010, 2, 1'b0, 1'b0, 32'h0, 1'b0);
    do_xfer(32'h2000_0004, HTRANS_NONSEQ, 1'b0, 4'b0100, 0, 1'b0, 1'b0, 32'h2222_2222, 1'b1);
    idle(2);

    // Single unmapped write, master goes IDLE during the first error cycle
    do_xfer(32'h8000_0000, HTRANS_NONSEQ, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    idle(3);
    check("err_cnt_1",  64'(err_cnt),  64'd1);
    check("err_addr_1", 64'(err_addr), {31'd0, 1'b1, 32'h8000_0000});

    // Back-to-back errors, then an IDLE to unmapped space gets zero-wait OKAY
    do_xfer(32'h8000_0004, HTRANS_NONSEQ, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    do_xfer(32'h9000_0000, HTRANS_NONSEQ, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    do_xfer(32'h8000_0000, HTRANS_IDLE,   1'b0, 4'b0000, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(3);
    check("err_cnt_3",  64'(err_cnt),  64'd3);
    check("err_addr_3", 64'(err_addr), {31'd0, 1'b0, 32'h9000_0000});

    // Counter saturation
    @(negedge clk);
    force dut.u_dflt.r_err_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.u_dflt.r_err_cnt;
    check("err_cnt_forced", 64'(err_cnt), 64'hFFFE);
    do_xfer(32'hF000_0000, HTRANS_NONSEQ, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    do_xfer(32'h4000_0000, HTRANS_NONSEQ, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    do_xfer(32'h5000_0000, HTRANS_NONSEQ, 1'b0, 4'b0000, 1, 1'b1, 1'b1, 32'h0, 1'b1);
    idle(3);
    check("err_cnt_sat",  64'(err_cnt),  64'hFFFF);
    check("err_addr_sat", 64'(err_addr), {31'd0, 1'b0, 32'h5000_0000});

    // Asynchronous reset in the first error cycle
    bus.HADDR  = 32'hA000_0000;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b0;
    track      = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.HTRANS = HTRANS_IDLE;
    #1;
    check("err1_hready", 64'(bus.HREADY), 64'd0);
    check("err1_hresp",  64'(bus.HRESP),  64'd1);
    rst = 1'b1;
    #1;
    check("arst_hready",  64'(bus.HREADY), 64'd1);
    check("arst_hresp",   64'(bus.HRESP),  64'd0);
    check("arst_errcnt",  64'(err_cnt),    64'd0);
    check("arst_erraddr", 64'(err_addr),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("arst_post_hready", 64'(bus.HREADY), 64'd1);
    check("arst_post_errcnt", 64'(err_cnt),    64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
